// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_add_sub
//  Purpose  : N-bit adder/subtractor that resolves CHUNK bits per stage.
//             It has a global-stall valid/ready pipeline and produces the
//             cout, ovf and zero flags.
//             Optional macro PIPELINED_ADD_SUB_SAT_EN adds a signed
//             saturation input (sat).
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_add_sub #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
`ifdef PIPELINED_ADD_SUB_SAT_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int STAGES = N / CHUNK;
    localparam logic [N-1:0] c_sat_max = {1'b0, {(N-1){1'b1}}};

    logic         w_adv;

    // Per-stage state: resolved low sum bits, operands still to be added,
    // and the carry into the next slice.
    logic         r_vld [STAGES];
    logic [N-1:0] r_a   [STAGES];
    logic [N-1:0] r_b   [STAGES];
    logic [N-1:0] r_sum [STAGES];
    logic         r_c   [STAGES];
`ifdef PIPELINED_ADD_SUB_SAT_EN
    logic         r_sat [STAGES];
`endif

    logic [N-1:0] r_s;
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;

    // Stall is global: the whole pipe moves only when the head can drain.
    assign w_adv     = !r_vld[STAGES-1] || out_ready;
    assign in_ready  = w_adv && !rst;
    assign out_valid = r_vld[STAGES-1];
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic           w_vld_in;
        logic [N-1:0]   w_a_in;
        logic [N-1:0]   w_b_in;
        logic [N-1:0]   w_sum_in;
        logic           w_c_in;
        logic [CHUNK:0] w_slice;
        logic [N-1:0]   w_sum_out;
`ifdef PIPELINED_ADD_SUB_SAT_EN
        logic           w_sat_in;
`endif

        if (k == 0) begin : g_head
            assign w_vld_in = in_valid && in_ready;
            assign w_a_in   = a;
            assign w_b_in   = sub ? ~b : b;
            assign w_c_in   = cin;
            assign w_sum_in = '0;
`ifdef PIPELINED_ADD_SUB_SAT_EN
            assign w_sat_in = sat;
`endif
        end else begin : g_body
            assign w_vld_in = r_vld[k-1];
            assign w_a_in   = r_a[k-1];
            assign w_b_in   = r_b[k-1];
            assign w_c_in   = r_c[k-1];
            assign w_sum_in = r_sum[k-1];
`ifdef PIPELINED_ADD_SUB_SAT_EN
            assign w_sat_in = r_sat[k-1];
`endif
        end

        assign w_slice = {1'b0, w_a_in[k*CHUNK +: CHUNK]}
                       + {1'b0, w_b_in[k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, w_c_in};

        always_comb begin
            w_sum_out                    = w_sum_in;
            w_sum_out[k*CHUNK +: CHUNK]  = w_slice[CHUNK-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[k] <= 1'b0;
            end else if (w_adv) begin
                r_vld[k] <= w_vld_in;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk) begin
                if (w_adv && w_vld_in) begin
                    r_a[k]   <= w_a_in;
                    r_b[k]   <= w_b_in;
                    r_sum[k] <= w_sum_out;
                    r_c[k]   <= w_slice[CHUNK];
`ifdef PIPELINED_ADD_SUB_SAT_EN
                    r_sat[k] <= w_sat_in;
`endif
                end
            end
        end else begin : g_last
            logic         w_c_msb;
            logic         w_ovf;
            logic [N-1:0] w_s;

            // Carry into the MSB is recovered from the MSB sum bit.
            assign w_c_msb = w_a_in[N-1] ^ w_b_in[N-1] ^ w_sum_out[N-1];
            assign w_ovf   = w_c_msb ^ w_slice[CHUNK];

`ifdef PIPELINED_ADD_SUB_SAT_EN
            // On overflow both operands share a sign, which is the true sign.
            always_comb begin
                w_s = w_sum_out;
                if (w_sat_in && w_ovf) begin
                    w_s = w_a_in[N-1] ? ~c_sat_max : c_sat_max;
                end
            end
`else
            assign w_s = w_sum_out;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s    <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv && w_vld_in) begin
                    r_s    <= w_s;
                    r_cout <= w_slice[CHUNK];
                    r_ovf  <= w_ovf;
                    r_zero <= (w_s == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_add_sub
//  Purpose  : Self-checking bench for pipelined_add_sub with N=32 and
//             CHUNK=8. It uses directed and random traffic against a
//             queue-based arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_add_sub;

    localparam int N      = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = N / CHUNK;
`ifdef PIPELINED_ADD_SUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic          sat = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  s;
    logic          cout;
    logic          ovf;
    logic          zero;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit check_lat = 1'b0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    pipelined_add_sub #(.N(N), .CHUNK(CHUNK)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
`ifdef PIPELINED_ADD_SUB_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: true signed result decides overflow and the clamp direction.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic msub, input logic mcin, input logic msat);
        exp_t        r;
        logic [31:0] bp;
        longint      ut;
        longint      st;
        bp     = msub ? ~mb : mb;
        ut     = longint'({32'b0, ma}) + longint'({32'b0, bp}) + longint'(mcin);
        st     = longint'($signed(ma)) + longint'($signed(bp)) + longint'(mcin);
        r.s    = ut[31:0];
        r.cout = ut[32];
        r.ovf  = (st > MAX_S) || (st < MIN_S);
        if (SAT_EN && msat && r.ovf) r.s = (st < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.zero = (r.s == 32'd0);
        r.acc  = 0;
        return r;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        a   = rnd32();
        b   = rnd32();
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        sat = 1'($urandom_range(0, 1));
    endtask

    // One clock: observe handshakes before the edge, return 1ns after it.
    task automatic cycle();
        exp_t e;
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("result_s", 64'(s), 64'(e.s));
                check_eq("result_flags", 64'({cout, ovf, zero}), 64'({e.cout, e.ovf, e.zero}));
                if (check_lat) check_eq("latency", 64'(cyc - e.acc), 64'(STAGES));
            end
        end
        if (!rst && in_valid && in_ready) begin
            e     = model(a, b, sub, cin, sat);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [31:0] ta, input logic [31:0] tb_op, input logic tsub,
                            input logic tcin, input logic tsat,
                            input logic [31:0] es, input logic [2:0] ef);
        int w;
        w         = 0;
        a         = ta;
        b         = tb_op;
        sub       = tsub;
        cin       = tcin;
        sat       = tsat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        while (!out_valid && w < 20) begin
            cycle();
            w++;
        end
        check_eq("dir_valid", 64'(out_valid), 64'd1);
        check_eq("dir_s", 64'(s), 64'(es));
        check_eq("dir_flags", 64'({cout, ovf, zero}), 64'(ef));
        cycle();
    endtask

    task automatic drain(input string tag);
        int w;
        w         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 50) begin
            cycle();
            w++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] head;

        // Reset state
        cycle();
        cycle();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_s", 64'(s), 64'd0);
        check_eq("rst_flags", 64'({cout, ovf, zero}), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        cycle();

        // Directed corner vectors, latency checked on each
        check_lat = 1'b1;
        directed(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3'b101);
        directed(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
        directed(32'd5,         32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 3'b000);
        directed(32'd5,         32'd7, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 3'b000);
        directed(32'h0000_0000, 32'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'b101);
        directed(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 3'b110);
`ifdef PIPELINED_ADD_SUB_SAT_EN
        directed(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 3'b110);
        directed(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b010);
`endif

        // Back-to-back stream of 10 with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_op();
            in_valid = 1'b1;
            check_eq("stream_in_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        drain("stream_drain");
        check_lat = 1'b0;

        // Fill with out_ready low, then stall three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 12 && !(out_valid && !in_ready); i++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        check_eq("fill_depth", 64'(exp_q.size()), 64'(STAGES));
        head = (exp_q.size() != 0) ? exp_q[0].s : 32'd0;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            cycle();
            check_eq("stall_in_ready", 64'(in_ready), 64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_hold_s", 64'(s), 64'(head));
        end
        // Release: one retires and one enters per cycle, no bubble
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
            check_eq("release_depth", 64'(exp_q.size()), 64'(STAGES));
        end
        drain("stall_drain");

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            rand_op();
            in_valid = 1'b1;
            cycle();
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        #1;
        check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
        cycle();
        exp_q.delete();
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_s", 64'(s), 64'd0);
        check_eq("midrst_flags", 64'({cout, ovf, zero}), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        end

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined n-bit adder/subtractor with a valid/ready handshake.
- Splits the operands into CHUNK-bit slices and resolves one slice per stage, so the carry chain per cycle is CHUNK bits rather than n.
- Produces sum, carry-out, signed overflow and zero flags.
- Serves as the wide-datapath arithmetic unit for multi-cycle execution and address-generation paths.

Parameters:
N, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits resolved per pipeline stage; 1 <= CHUNK <= N.
STAGES, N/CHUNK, derived localparam; pipeline depth and latency in cycles.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and controls valid this cycle.
in_ready  output  1  block accepts an operation this cycle.
a  input  N  operand A.
b  input  N  operand B.
sub  input  1  1 = use ~b (subtract); 0 = use b.
cin  input  1  carry into bit 0 (1 with sub=1 gives a-b; 0 with sub=1 gives a-b-1).
out_valid  output  1  result outputs hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
s  output  N  sum: a + (sub ? ~b : b) + cin, modulo 2^N.
cout  output  1  carry out of bit N-1.
ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.
zero  output  1  s == 0.

Behaviour:
- Reset: synchronous and active-high. While rst=1 at a clock edge, all stage valid bits clear and s, cout, ovf, zero and out_valid are 0 after the edge.
- Reset mid-operation: all in-flight operations are discarded. in_ready = 0 while rst is high.
- Advance enable: adv = !out_valid || out_ready (combinational). in_ready = adv && !rst.
  - When adv=1, every stage shifts forward one position.
  - When adv=0, all stages hold their valid bits, data and carries.
- Pipeline bubbles are not squeezed out; stall is global.
- Accept: a transfer occurs when in_valid && in_ready. Stage 0 then captures a, b' = (sub ? ~b : b), cin and valid=1.
- No transfer with adv=1: stage 0 loads valid=0; its data is don't-care.
- Stage k (0..STAGES-1):
  - Computes slice k, bits [k*CHUNK +: CHUNK] = a_slice + b'_slice + carry_k.
  - Registers the slice result and carry_{k+1}.
  - Passes the remaining unresolved upper slices of a and b' forward.
  - Already-resolved lower sum bits propagate alongside the operation.
- Final stage additionally registers cout, the carry into bit N-1 (for ovf) and zero, all derived from the complete sum.
- Latency: an operation accepted at edge t is visible on outputs with out_valid=1 after edge t+STAGES-1, assuming no stall.
  - Throughput is 1 operation per cycle when out_ready stays high.
- Output hold: while out_valid=1 and out_ready=0, s, cout, ovf and zero are stable and in_ready=0.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: one result retires and one operation enters in the same cycle, with no bubble.
- CHUNK == N: STAGES=1, a single registered stage with latency 1.
- Ordering: results emerge strictly in acceptance order; none are lost or duplicated under any out_ready pattern.
- Flags are computed on the raw modular sum.

Optional Feature:
- Macro: PIPELINED_ADD_SUB_SAT_EN.
- Defined: adds input sat (1 bit), registered with the operation at acceptance.
  - With sat=1 and signed overflow, s is clamped to 0x7FF..F when the true result is positive, or 0x800..0 when it is negative. ovf still reports 1.
  - zero reflects the clamped s.
  - cout is unchanged (raw carry).
  - Pipeline latency is unchanged; the clamp is applied in the final stage.
- Not defined: the sat port does not exist and s is always the modular sum.

Test Plan:
- N=32, CHUNK=8:
  - a=0xFFFFFFFF, b=1, sub=0, cin=0 -> after 4 cycles, s=0, cout=1, zero=1, ovf=0.
  - a=0x7FFFFFFF, b=1, sub=0, cin=0 -> s=0x80000000, ovf=1, cout=0.
  - a=5, b=7, sub=1, cin=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Same operands with cin=0 -> s=0xFFFFFFFD.
- Back-to-back stream of 10 operations with out_ready=1 -> 10 results on 10 consecutive cycles in order. First result appears 4 cycles after the first accept.
- Full pipeline, out_ready held 0 for 3 cycles -> in_ready=0, and s stays stable at the head result. Release -> all results arrive in order, none dropped.
- rst asserted for 1 cycle with 3 operations in flight -> out_valid=0 and all outputs 0 after the edge. No stale results appear afterwards.
- With PIPELINED_ADD_SUB_SAT_EN: a=0x80000000, b=1, sub=1, cin=1, sat=1 -> s=0x80000000, ovf=1.
